// File: rtl/divider.sv
// Iterative RV64M divider (DIV/DIVU/REM/REMU and their W forms) for the EX stage.
// Restoring radix-2^BITS_PER_CYCLE core with sign pre-correction in INIT and
// post-correction plus RISC-V special cases in FIX.
// Optional build macro DIVIDER_EARLY_OUT_EN: INIT resolves divide-by-zero, signed
// overflow and |dividend| < |divisor| directly and jumps to DONE.
// Handshake: an operation starts when valid_i && div_ctrl_i.is_div is seen in IDLE;
// stall_o holds the pipeline from that cycle until DONE, where rslt_o carries the
// result for exactly one cycle with stall_o low so the instruction advances.

package rei_pkg;
    localparam int XLEN = 64;

    typedef struct packed {
        logic is_div;
        logic is_src_signed;
        logic is_rem;
        logic is_word;
    } div_ctrl_s;
endpackage

module divider
    import rei_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            stall_o,
    input  div_ctrl_s       div_ctrl_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    output logic [XLEN-1:0] rslt_o
);

    generate
        if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4)) begin : g_bpc_check
            $fatal(1, "divider: BITS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam int CNT_W = $clog2(XLEN / BITS_PER_CYCLE + 1);
    localparam logic [CNT_W-1:0] N_DW = CNT_W'(XLEN / BITS_PER_CYCLE);
    localparam logic [CNT_W-1:0] N_W  = CNT_W'(32 / BITS_PER_CYCLE);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        CALC,
        FIX,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   src1_q, src1_d;
    logic [XLEN-1:0]   src2_q, src2_d;
    logic              signed_q, signed_d;
    logic              op_rem_q, op_rem_d;
    logic              word_q, word_d;
    logic [XLEN-1:0]   dsr_q, dsr_d;     // divisor magnitude
    logic [XLEN-1:0]   quo_q, quo_d;     // dividend bits shift out, quotient bits shift in
    logic [XLEN-1:0]   prem_q, prem_d;   // partial remainder
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic [XLEN-1:0]   rslt_q, rslt_d;

    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag;
    logic              a_neg, b_neg, div_zero, ovf;
    logic [XLEN-1:0]   step_quo, step_rem;
    logic [XLEN-1:0]   q_fix, r_fix, q_val, r_val;

    // Word results always sign-extend bit 31, unsigned forms included.
    function automatic logic [XLEN-1:0] fin(input logic w, input logic [XLEN-1:0] v);
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    // Operand conditioning from the latched operands: extension, magnitudes, special cases.
    always_comb begin
        a_ext = src1_q;
        b_ext = src2_q;
        if (word_q) begin
            a_ext = signed_q ? {{(XLEN-32){src1_q[31]}}, src1_q[31:0]} : {{(XLEN-32){1'b0}}, src1_q[31:0]};
            b_ext = signed_q ? {{(XLEN-32){src2_q[31]}}, src2_q[31:0]} : {{(XLEN-32){1'b0}}, src2_q[31:0]};
        end
        a_neg    = signed_q && a_ext[XLEN-1];
        b_neg    = signed_q && b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        ovf      = signed_q && (b_ext == '1) &&
                   (word_q ? (a_ext == {{(XLEN-31){1'b1}}, {31{1'b0}}})
                           : (a_ext == {1'b1, {(XLEN-1){1'b0}}}));
    end

    // One CALC cycle: BITS_PER_CYCLE restoring shift/trial-subtract steps.
    always_comb begin
        logic [XLEN:0] shifted;
        logic [XLEN:0] trial;
        logic          no_borrow;
        step_quo  = quo_q;
        step_rem  = prem_q;
        shifted   = '0;
        trial     = '0;
        no_borrow = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            shifted   = {step_rem, step_quo[XLEN-1]};
            trial     = shifted - {1'b0, dsr_q};
            no_borrow = !trial[XLEN];
            step_rem  = no_borrow ? trial[XLEN-1:0] : shifted[XLEN-1:0];
            step_quo  = {step_quo[XLEN-2:0], no_borrow};
        end
    end

    // Sign post-correction with RISC-V divide-by-zero and overflow overrides.
    always_comb begin
        q_fix = q_neg_q ? -quo_q : quo_q;
        r_fix = r_neg_q ? -prem_q : prem_q;
        q_val = div_zero ? '1 : (ovf ? a_ext : q_fix);
        r_val = div_zero ? a_ext : (ovf ? '0 : r_fix);
    end

    // Next-state and datapath update for the IDLE/INIT/CALC/FIX/DONE sequence.
    always_comb begin
        state_d  = state_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        signed_d = signed_q;
        op_rem_d = op_rem_q;
        word_d   = word_q;
        dsr_d    = dsr_q;
        quo_d    = quo_q;
        prem_d   = prem_q;
        cnt_d    = cnt_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        rslt_d   = rslt_q;
        case (state_q)
            IDLE: begin
                if (valid_i && div_ctrl_i.is_div) begin
                    src1_d   = src1_i;
                    src2_d   = src2_i;
                    signed_d = div_ctrl_i.is_src_signed;
                    op_rem_d = div_ctrl_i.is_rem;
                    word_d   = div_ctrl_i.is_word;
                    state_d  = INIT;
                end
            end
            INIT: begin
                dsr_d   = b_mag;
                quo_d   = word_q ? (a_mag << (XLEN - 32)) : a_mag;
                prem_d  = '0;
                cnt_d   = word_q ? N_W : N_DW;
                q_neg_d = a_neg ^ b_neg;
                r_neg_d = a_neg;
                state_d = CALC;
`ifdef DIVIDER_EARLY_OUT_EN
                if (div_zero || ovf || (a_mag < b_mag)) begin
                    rslt_d  = fin(word_q,
                                  div_zero ? (op_rem_q ? a_ext : '1) :
                                  ovf      ? (op_rem_q ? '0 : a_ext) :
                                             (op_rem_q ? a_ext : '0));
                    state_d = DONE;
                end
`endif
            end
            CALC: begin
                quo_d  = step_quo;
                prem_d = step_rem;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                rslt_d  = fin(word_q, op_rem_q ? r_val : q_val);
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register; the only reset flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; contents are don't-care outside an operation.
    always_ff @(posedge clk_i) begin
        src1_q   <= src1_d;
        src2_q   <= src2_d;
        signed_q <= signed_d;
        op_rem_q <= op_rem_d;
        word_q   <= word_d;
        dsr_q    <= dsr_d;
        quo_q    <= quo_d;
        prem_q   <= prem_d;
        cnt_q    <= cnt_d;
        q_neg_q  <= q_neg_d;
        r_neg_q  <= r_neg_d;
        rslt_q   <= rslt_d;
    end

    // Stall from the accepting cycle through FIX; result only in DONE.
    always_comb begin
        stall_o = !rst_i && ((state_q == INIT) || (state_q == CALC) || (state_q == FIX) ||
                             ((state_q == IDLE) && valid_i && div_ctrl_i.is_div));
        rslt_o  = (!rst_i && (state_q == DONE)) ? rslt_q : '0;
    end

endmodule

// File: tb/tb_divider.sv
// Directed and random bench for divider: latency, stall window, results, reset abort.
module tb_divider;
  import rei_pkg::*;

  localparam int B = 1;
`ifdef DIVIDER_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic            valid;
  logic            stall;
  div_ctrl_s       ctrl;
  logic [63:0]     src1;
  logic [63:0]     src2;
  logic [63:0]     rslt;

  logic [63:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  divider #(.BITS_PER_CYCLE(B)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .valid_i    (valid),
    .stall_o    (stall),
    .div_ctrl_i (ctrl),
    .src1_i     (src1),
    .src2_i     (src2),
    .rslt_o     (rslt)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: RISC-V division semantics via language operators
  function automatic logic [63:0] ref_div(input bit s, input bit r, input bit w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, r32;
    logic [63:0] r64;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0)                                   r32 = r ? a32 : 32'hFFFF_FFFF;
      else if (s && a32 == 32'h8000_0000 && b32 == '1)    r32 = r ? 32'd0 : a32;
      else if (s)                                         r32 = r ? 32'($signed(a32) % $signed(b32)) : 32'($signed(a32) / $signed(b32));
      else                                                r32 = r ? a32 % b32 : a32 / b32;
      return {{32{r32[31]}}, r32};
    end
    if (b == 64'd0)                                       r64 = r ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (s && a == 64'h8000_0000_0000_0000 && b == '1) r64 = r ? 64'd0 : a;
    else if (s)                                           r64 = r ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
    else                                                  r64 = r ? a % b : a / b;
    return r64;
  endfunction

  // early-out predicate: divisor zero, signed overflow, |a| < |b|
  function automatic bit ref_early(input bit s, input bit w, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ae, be, am, bm;
    bit ov;
    ae = w ? (s ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]}) : a;
    be = w ? (s ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]}) : b;
    am = (s && ae[63]) ? -ae : ae;
    bm = (s && be[63]) ? -be : be;
    ov = s && (be == '1) && (w ? (ae == 64'hFFFF_FFFF_8000_0000) : (ae == 64'h8000_0000_0000_0000));
    return (be == 64'd0) || ov || (am < bm);
  endfunction

  // driver: start one op, hold valid until DONE, check stall window, latency and result
  task automatic run_op(input string tag, input bit s, input bit r, input bit w,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp_val);
    int  lat, cyc, stall_cnt;
    bit  leak;
    logic [63:0] e;
    lat = (EO && ref_early(s, w, a, b)) ? 2 : ((w ? 32 : 64) / B + 3);
    @(posedge clk); #1;
    valid = 1'b1;
    ctrl.is_div = 1'b1; ctrl.is_src_signed = s; ctrl.is_rem = r; ctrl.is_word = w;
    src1 = a; src2 = b;
    exp_q.push_back(exp_val);
    #1;
    check({tag, "/start_stall"}, 64'(stall), 64'd1);
    stall_cnt = 1;
    cyc = 0;
    leak = 1'b0;
    while (cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (!stall) break;
      stall_cnt++;
      if (rslt !== 64'd0) leak = 1'b1;
    end
    check({tag, "/latency"}, 64'(cyc), 64'(lat));
    check({tag, "/stall_cycles"}, 64'(stall_cnt), 64'(lat));
    check({tag, "/no_early_rslt"}, 64'(leak), 64'd0);
    e = exp_q.pop_front();
    check({tag, "/rslt"}, rslt, e);
    valid = 1'b0;
    ctrl = '0;
    @(posedge clk); #1;
    check({tag, "/rslt_cleared"}, rslt, 64'd0);
    check({tag, "/idle_stall"}, 64'(stall), 64'd0);
  endtask

  initial begin
    logic [63:0] ra, rb;
    int op;
    rst = 1'b1;
    valid = 1'b0;
    ctrl = '0;
    src1 = '0;
    src2 = '0;

    // reset: outputs low even with a divide request presented
    repeat (2) @(posedge clk);
    #1;
    valid = 1'b1; ctrl.is_div = 1'b1; src1 = 64'd10; src2 = 64'd3;
    #1;
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_rslt", rslt, 64'd0);
    valid = 1'b0; ctrl = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // valid without is_div is ignored
    valid = 1'b1; ctrl.is_div = 1'b0; src1 = 64'd50; src2 = 64'd5;
    repeat (3) begin
      @(posedge clk); #1;
      check("non_div_stall", 64'(stall), 64'd0);
    end
    valid = 1'b0; ctrl = '0;

    // directed operations
    run_op("divu_100_7",  0, 0, 0, 64'd100, 64'd7, 64'd14);
    run_op("remu_100_7",  0, 1, 0, 64'd100, 64'd7, 64'd2);
    run_op("div_m7_2",    1, 0, 0, -64'd7,  64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("rem_m7_2",    1, 1, 0, -64'd7,  64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("rem_7_m2",    1, 1, 0, 64'd7,  -64'd2, 64'd1);
    run_op("div_5_0",     1, 0, 0, 64'd5,   64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("remu_5_0",    0, 1, 0, 64'd5,   64'd0, 64'd5);
    run_op("div_ovf",     1, 0, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
    run_op("rem_ovf",     1, 1, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    run_op("divw_m7_2",   1, 0, 1, 64'h0000_0001_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divuw_max_1", 0, 0, 1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("remw_ovf",    1, 1, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0);
    run_op("divu_3_10",   0, 0, 0, 64'd3,  64'd10, 64'd0);
    run_op("remu_3_10",   0, 1, 0, 64'd3,  64'd10, 64'd3);

    // reset in cycle 10 of a DIVU aborts it
    @(posedge clk); #1;
    valid = 1'b1; ctrl.is_div = 1'b1; src1 = 64'd1000; src2 = 64'd3;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_stall", 64'(stall), 64'd0);
    check("abort_rslt", rslt, 64'd0);
    valid = 1'b0; ctrl = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_abort_stall", 64'(stall), 64'd0);
    run_op("divu_9_3_after_reset", 0, 0, 0, 64'd9, 64'd3, 64'd3);

    // random operations against the reference model
    for (int i = 0; i < 8; i++) begin
      op = $urandom_range(0, 7);
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       rb = 64'($urandom_range(0, 5));
        1:       rb = -64'($urandom_range(1, 9));
        2:       rb = {32'd0, $urandom};
        default: rb = {$urandom, $urandom};
      endcase
      run_op($sformatf("rand%0d_op%0d", i, op), op[0], op[1], op[2], ra, rb,
             ref_div(op[0], op[1], op[2], ra, rb));
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
